iob_tb_bus_arbiter: RTL and testbench



---
 rtl/iob_tb_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_iob_tb_bus_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_tb_bus_arbiter.sv
// Round-robin arbiter that multiplexes N_MST IOb native hosts onto one target port.
// Only one transaction is in flight at a time, and reads are guarded by an optional timeout.
module iob_tb_bus_arbiter #(
    parameter int N_MST      = 2,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 256
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic [N_MST-1:0]                            m_avalid_i,
    input  logic [N_MST*ADDR_W-1:0]                     m_addr_i,
    input  logic [N_MST*DATA_W-1:0]                     m_wdata_i,
    input  logic [N_MST*(DATA_W/8)-1:0]                 m_wstrb_i,
    output logic [N_MST-1:0]                            m_ready_o,
    output logic [N_MST-1:0]                            m_rvalid_o,
    output logic [DATA_W-1:0]                           m_rdata_o,
    output logic                                        s_avalid_o,
    output logic [ADDR_W-1:0]                           s_addr_o,
    output logic [DATA_W-1:0]                           s_wdata_o,
    output logic [DATA_W/8-1:0]                         s_wstrb_o,
    input  logic                                        s_ready_i,
    input  logic                                        s_rvalid_i,
    input  logic [DATA_W-1:0]                           s_rdata_i,
    output logic                                        timeout_o,
    output logic [((N_MST > 1) ? $clog2(N_MST) : 1)-1:0] grant_o
);

    localparam int GW = (N_MST > 1) ? $clog2(N_MST) : 1;
    localparam int SW = DATA_W / 8;
    localparam int CW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(RD_TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, RD} state_t;

    state_t                         state_q, state_d;
    logic [GW-1:0]                  grant_q, grant_d, winner;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           to_q, to_d;
    logic [N_MST-1:0]               hi_req;

    logic [N_MST-1:0][ADDR_W-1:0]   addr_v;
    logic [N_MST-1:0][DATA_W-1:0]   wdata_v;
    logic [N_MST-1:0][SW-1:0]       wstrb_v;

    assign addr_v    = m_addr_i;
    assign wdata_v   = m_wdata_i;
    assign wstrb_v   = m_wstrb_i;
    assign grant_o   = grant_q;
    assign timeout_o = to_q;

    // Requests above the last grant take precedence; otherwise wrap to the lowest requester.
    always_comb begin
        hi_req = '0;
        for (int i = 0; i < N_MST; i++)
            hi_req[i] = m_avalid_i[i] && (GW'(i) > grant_q);
        winner = grant_q;
        for (int i = N_MST - 1; i >= 0; i--)
            if (m_avalid_i[i]) winner = GW'(i);
        if (|hi_req)
            for (int i = N_MST - 1; i >= 0; i--)
                if (hi_req[i]) winner = GW'(i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= GW'(N_MST - 1);
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    // Host-facing outputs are forced quiet while reset is asserted, so a read that is
    // outstanding at reset is dropped without a response.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        cnt_d      = cnt_q;
        to_d       = to_q;
        m_ready_o  = '0;
        m_rvalid_o = '0;
        m_rdata_o  = '0;
        s_avalid_o = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        s_wstrb_o  = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (|m_avalid_i) begin
                        grant_d = winner;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    s_avalid_o         = m_avalid_i[grant_q];
                    s_addr_o           = addr_v[grant_q];
                    s_wdata_o          = wdata_v[grant_q];
                    s_wstrb_o          = wstrb_v[grant_q];
                    m_ready_o[grant_q] = s_ready_i;
                    if (!m_avalid_i[grant_q]) begin
                        state_d = IDLE;
                    end else if (s_ready_i) begin
                        if (|wstrb_v[grant_q]) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RD;
                            cnt_d   = '0;
                        end
                    end
                end
                RD: begin
                    // A real response wins over a timeout that expires in the same cycle.
                    if (s_rvalid_i) begin
                        m_rvalid_o[grant_q] = 1'b1;
                        m_rdata_o           = s_rdata_i;
                        state_d             = IDLE;
                    end else if (RD_TIMEOUT != 0 && cnt_q == TO_CNT) begin
                        m_rvalid_o[grant_q] = 1'b1;
                        m_rdata_o           = '1;
                        to_d                = 1'b1;
                        state_d             = IDLE;
                    end else if (RD_TIMEOUT != 0) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_tb_bus_arbiter.sv
// Bench for iob_tb_bus_arbiter: directed scenarios plus a randomized run that is
// scored against a transaction-level round-robin/target model.
module tb_iob_tb_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
    localparam int GW = 2;

    logic                   clk, rst;
    logic [N-1:0]           m_avalid;
    logic [N-1:0][AW-1:0]   m_addr;
    logic [N-1:0][DW-1:0]   m_wdata;
    logic [N-1:0][SW-1:0]   m_wstrb;
    logic [N-1:0]           m_ready_o, m_rvalid_o;
    logic [DW-1:0]          m_rdata_o;
    logic                   s_avalid_o;
    logic [AW-1:0]          s_addr_o;
    logic [DW-1:0]          s_wdata_o;
    logic [SW-1:0]          s_wstrb_o;
    logic                   s_ready_i, s_rvalid_i;
    logic [DW-1:0]          s_rdata_i;
    logic                   timeout_o;
    logic [GW-1:0]          grant_o;

    int n_tests = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int last_grant;
    bit to_flag;

    logic             pend_v     [N];
    logic [AW-1:0]    pend_addr  [N];
    logic [DW-1:0]    pend_wdata [N];
    logic [SW-1:0]    pend_wstrb [N];

    iob_tb_bus_arbiter #(.N_MST(N), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_avalid_i(m_avalid), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_ready_o(m_ready_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
        .s_avalid_o(s_avalid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
        .s_ready_i(s_ready_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .timeout_o(timeout_o), .grant_o(grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target handshakes as seen just before each rising edge (inputs only change at negedge).
    always @(negedge clk) begin
        #2;
        if (s_avalid_o && s_ready_i) acc_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference arbitration: first requester searching upward from the previous grant.
    function automatic int rr_pick(int last, logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (mask[c]) return c;
        end
        return last;
    endfunction

    function automatic logic [N-1:0] onehot(int h);
        logic [N-1:0] v;
        v = '0;
        v[h] = 1'b1;
        return v;
    endfunction

    task automatic clr_inputs;
        m_avalid = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_ready_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    endtask

    task automatic set_host(int h, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
        m_avalid[h] = 1'b1; m_addr[h] = a; m_wdata[h] = d; m_wstrb[h] = s;
    endtask

    task automatic drive_pend;
        for (int h = 0; h < N; h++) begin
            m_avalid[h] = pend_v[h];
            m_addr[h]   = pend_addr[h];
            m_wdata[h]  = pend_wdata[h];
            m_wstrb[h]  = pend_wstrb[h];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        m_avalid = '1;
        for (int h = 0; h < N; h++) begin
            m_addr[h] = AW'($urandom); m_wdata[h] = $urandom; m_wstrb[h] = SW'($urandom);
        end
        s_ready_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = '1;
        repeat (3) begin
            @(negedge clk); #1;
            n_tests++;
            if ({s_avalid_o, m_ready_o, m_rvalid_o, s_addr_o, s_wdata_o, s_wstrb_o, m_rdata_o} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: s_avalid=%b m_ready=%b m_rvalid=%b s_addr=%h s_wdata=%h s_wstrb=%h m_rdata=%h, expected all zero",
                         s_avalid_o, m_ready_o, m_rvalid_o, s_addr_o, s_wdata_o, s_wstrb_o, m_rdata_o);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        clr_inputs();
        #1;
        n_tests++;
        if (grant_o !== GW'(N - 1)) begin
            n_fail++; $display("FAIL reset_grant: got %0d expected %0d", grant_o, N - 1);
        end
        n_tests++;
        if (timeout_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o);
        end
        n_tests++;
        if ({s_avalid_o, m_ready_o, m_rvalid_o, m_rdata_o} !== '0) begin
            n_fail++; $display("FAIL post_reset_idle: s_avalid=%b m_ready=%b m_rvalid=%b, expected 0", s_avalid_o, m_ready_o, m_rvalid_o);
        end
        last_grant = N - 1;
        to_flag = 1'b0;
    endtask

    task automatic test_single_write;
        @(negedge clk);
        set_host(0, 16'h0010, 32'h0000_00A5, 4'h1);
        s_ready_i = 1'b1;
        #1;
        n_tests++;
        if ({s_avalid_o, m_ready_o} !== '0) begin
            n_fail++; $display("FAIL write_arb_cycle: s_avalid=%b m_ready=%b expected 0/000", s_avalid_o, m_ready_o);
        end
        @(negedge clk); #1;
        n_tests++;
        if ({grant_o, s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o, m_ready_o} !== {GW'(0), 1'b1, 16'h0010, 32'h0000_00A5, 4'h1, 3'b001}) begin
            n_fail++;
            $display("FAIL write_req: grant=%0d s_avalid=%b addr=%h wdata=%h wstrb=%h m_ready=%b expected 0 1 0010 000000a5 1 001",
                     grant_o, s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o, m_ready_o);
        end
        @(negedge clk);
        clr_inputs();
        #1;
        n_tests++;
        if ({s_avalid_o, m_ready_o, m_rvalid_o} !== '0) begin
            n_fail++; $display("FAIL write_back_idle: s_avalid=%b m_ready=%b m_rvalid=%b expected 0", s_avalid_o, m_ready_o, m_rvalid_o);
        end
        last_grant = 0;
    endtask

    task automatic test_read;
        @(negedge clk);
        set_host(1, 16'h0004, 32'hCAFE_F00D, 4'h0);
        s_ready_i = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({grant_o, s_avalid_o, s_addr_o, s_wstrb_o, m_ready_o} !== {GW'(1), 1'b1, 16'h0004, 4'h0, 3'b010}) begin
            n_fail++;
            $display("FAIL read_req: grant=%0d s_avalid=%b addr=%h wstrb=%h m_ready=%b expected 1 1 0004 0 010",
                     grant_o, s_avalid_o, s_addr_o, s_wstrb_o, m_ready_o);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            clr_inputs();
            s_rvalid_i = (k == 3);
            s_rdata_i  = (k == 3) ? 32'h1234_5678 : $urandom;
            #1;
            n_tests++;
            if (k < 3) begin
                if ({s_avalid_o, m_rvalid_o, m_rdata_o} !== '0) begin
                    n_fail++; $display("FAIL read_wait%0d: s_avalid=%b m_rvalid=%b m_rdata=%h expected 0", k, s_avalid_o, m_rvalid_o, m_rdata_o);
                end
            end else if ({m_rvalid_o, m_rdata_o} !== {3'b010, 32'h1234_5678}) begin
                n_fail++; $display("FAIL read_resp: m_rvalid=%b m_rdata=%h expected 010 12345678", m_rvalid_o, m_rdata_o);
            end
        end
        @(negedge clk);
        clr_inputs();
        #1;
        n_tests++;
        if ({m_rvalid_o, m_rdata_o} !== '0) begin
            n_fail++; $display("FAIL read_after: m_rvalid=%b m_rdata=%h expected 0", m_rvalid_o, m_rdata_o);
        end
        last_grant = 1;
    endtask

    task automatic test_contention;
        int exp;
        @(negedge clk);
        set_host(0, 16'h0100, 32'h1111_0000, 4'hF);
        set_host(1, 16'h0101, 32'h2222_0000, 4'hF);
        s_ready_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (t > 0) @(negedge clk);
            #1;
            n_tests++;
            if (s_avalid_o !== 1'b0) begin
                n_fail++; $display("FAIL contention_idle%0d: s_avalid=%b expected 0", t, s_avalid_o);
            end
            exp = rr_pick(last_grant, 3'b011);
            @(negedge clk); #1;
            n_tests++;
            if ({grant_o, m_ready_o, s_addr_o} !== {GW'(exp), onehot(exp), AW'(16'h0100 + exp)}) begin
                n_fail++; $display("FAIL contention_grant%0d: grant=%0d m_ready=%b addr=%h expected %0d %b %h",
                                   t, grant_o, m_ready_o, s_addr_o, exp, onehot(exp), 16'h0100 + exp);
            end
            last_grant = exp;
        end
        @(negedge clk);
        clr_inputs();
    endtask

    task automatic test_timeout;
        @(negedge clk);
        set_host(2, 16'h0BAD, 32'h0, 4'h0);
        s_ready_i = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({grant_o, m_ready_o} !== {GW'(2), 3'b100}) begin
            n_fail++; $display("FAIL timeout_req: grant=%0d m_ready=%b expected 2 100", grant_o, m_ready_o);
        end
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clk);
            clr_inputs();
            s_rdata_i = $urandom;
            #1;
            n_tests++;
            if (k <= TO) begin
                if ({m_rvalid_o, m_rdata_o, timeout_o} !== '0) begin
                    n_fail++; $display("FAIL timeout_wait%0d: m_rvalid=%b m_rdata=%h timeout=%b expected 0", k, m_rvalid_o, m_rdata_o, timeout_o);
                end
            end else if ({m_rvalid_o, m_rdata_o} !== {3'b100, 32'hFFFF_FFFF}) begin
                n_fail++; $display("FAIL timeout_pulse: m_rvalid=%b m_rdata=%h expected 100 ffffffff", m_rvalid_o, m_rdata_o);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_rvalid_i = (k == 0);
            s_rdata_i  = 32'hDEAD_BEEF;
            #1;
            n_tests++;
            if ({m_rvalid_o, m_rdata_o, timeout_o} !== {3'b000, 32'h0, 1'b1}) begin
                n_fail++; $display("FAIL timeout_sticky%0d: m_rvalid=%b m_rdata=%h timeout=%b expected 000 0 1", k, m_rvalid_o, m_rdata_o, timeout_o);
            end
        end
        clr_inputs();
        last_grant = 2;
        to_flag = 1'b1;
    endtask

    task automatic test_reset_in_rd;
        @(negedge clk);
        set_host(0, 16'h0040, 32'h0, 4'h0);
        s_ready_i = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if ({grant_o, m_ready_o} !== {GW'(0), 3'b001}) begin
            n_fail++; $display("FAIL rstrd_req: grant=%0d m_ready=%b expected 0 001", grant_o, m_ready_o);
        end
        @(negedge clk);
        clr_inputs();
        @(negedge clk);
        rst = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'h5555_AAAA;
        #1;
        n_tests++;
        if ({m_rvalid_o, m_rdata_o} !== '0) begin
            n_fail++; $display("FAIL rstrd_drop: m_rvalid=%b m_rdata=%h expected 0", m_rvalid_o, m_rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        set_host(0, 16'h0050, 32'h5, 4'h3);
        set_host(1, 16'h0051, 32'h6, 4'h3);
        s_ready_i = 1'b1;
        #1;
        n_tests++;
        if ({m_rvalid_o, grant_o, timeout_o} !== {3'b000, GW'(N - 1), 1'b0}) begin
            n_fail++; $display("FAIL rstrd_after: m_rvalid=%b grant=%0d timeout=%b expected 000 %0d 0", m_rvalid_o, grant_o, timeout_o, N - 1);
        end
        @(negedge clk);
        s_rvalid_i = 1'b0;
        #1;
        n_tests++;
        if ({grant_o, m_ready_o, s_addr_o} !== {GW'(0), 3'b001, 16'h0050}) begin
            n_fail++; $display("FAIL rstrd_next_grant: grant=%0d m_ready=%b addr=%h expected 0 001 0050", grant_o, m_ready_o, s_addr_o);
        end
        @(negedge clk);
        clr_inputs();
        last_grant = 0;
        to_flag = 1'b0;
    endtask

    task automatic test_withdraw;
        int acc_before;
        acc_before = acc_cnt;
        @(negedge clk);
        set_host(1, 16'h0077, 32'h77, 4'hF);
        @(negedge clk); #1;
        n_tests++;
        if ({grant_o, s_avalid_o, m_ready_o} !== {GW'(1), 1'b1, 3'b000}) begin
            n_fail++; $display("FAIL withdraw_req: grant=%0d s_avalid=%b m_ready=%b expected 1 1 000", grant_o, s_avalid_o, m_ready_o);
        end
        @(negedge clk);
        m_avalid = '0;
        #1;
        n_tests++;
        if (s_avalid_o !== 1'b0) begin
            n_fail++; $display("FAIL withdraw_drop: s_avalid=%b expected 0", s_avalid_o);
        end
        @(negedge clk);
        set_host(0, 16'h0080, 32'h8, 4'hF);
        set_host(1, 16'h0081, 32'h9, 4'hF);
        s_ready_i = 1'b1;
        #1;
        n_tests++;
        if ({s_avalid_o, m_ready_o} !== '0) begin
            n_fail++; $display("FAIL withdraw_idle: s_avalid=%b m_ready=%b expected 0 000", s_avalid_o, m_ready_o);
        end
        n_tests++;
        if (acc_cnt !== acc_before) begin
            n_fail++; $display("FAIL withdraw_no_xfer: handshakes=%0d expected %0d", acc_cnt - acc_before, 0);
        end
        @(negedge clk); #1;
        n_tests++;
        if ({grant_o, m_ready_o, s_addr_o} !== {GW'(0), 3'b001, 16'h0080}) begin
            n_fail++; $display("FAIL withdraw_next: grant=%0d m_ready=%b addr=%h expected 0 001 0080", grant_o, m_ready_o, s_addr_o);
        end
        @(negedge clk);
        clr_inputs();
        last_grant = 0;
    endtask

    task automatic test_random;
        int exp, d, lat, nrd;
        bit is_rd, answered;
        logic [N-1:0] mask;
        logic [DW-1:0] rd;
        for (int h = 0; h < N; h++) pend_v[h] = 1'b0;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            for (int h = 0; h < N; h++) begin
                if (!pend_v[h] && $urandom_range(0, 1) == 1) begin
                    pend_v[h]     = 1'b1;
                    pend_addr[h]  = AW'($urandom);
                    pend_wdata[h] = $urandom;
                    pend_wstrb[h] = ($urandom_range(0, 1) == 1) ? '0 : SW'($urandom_range(1, 15));
                end
            end
            mask = '0;
            for (int h = 0; h < N; h++) mask[h] = pend_v[h];
            if (mask == '0) begin
                exp = $urandom_range(0, N - 1);
                pend_v[exp] = 1'b1; pend_addr[exp] = AW'($urandom);
                pend_wdata[exp] = $urandom; pend_wstrb[exp] = SW'($urandom_range(1, 15));
                mask[exp] = 1'b1;
            end
            drive_pend();
            s_ready_i = 1'($urandom); s_rvalid_i = 1'($urandom); s_rdata_i = $urandom;
            #1;
            n_tests++;
            if ({s_avalid_o, m_ready_o, m_rvalid_o, m_rdata_o, grant_o, timeout_o} !== {1'b0, 3'b000, 3'b000, 32'h0, GW'(last_grant), to_flag}) begin
                n_fail++; $display("FAIL rnd_idle%0d: s_avalid=%b m_ready=%b m_rvalid=%b m_rdata=%h grant=%0d timeout=%b expected 0 000 000 0 %0d %b",
                                   t, s_avalid_o, m_ready_o, m_rvalid_o, m_rdata_o, grant_o, timeout_o, last_grant, to_flag);
            end
            exp = rr_pick(last_grant, mask);
            d = $urandom_range(0, 2);
            for (int w = 0; w <= d; w++) begin
                @(negedge clk);
                s_ready_i = (w == d); s_rvalid_i = 1'($urandom); s_rdata_i = $urandom;
                #1;
                n_tests++;
                if ({grant_o, m_ready_o, m_rvalid_o} !== {GW'(exp), (w == d) ? onehot(exp) : 3'b000, 3'b000}) begin
                    n_fail++; $display("FAIL rnd_grant%0d: grant=%0d m_ready=%b m_rvalid=%b expected %0d %b 000",
                                       t, grant_o, m_ready_o, m_rvalid_o, exp, (w == d) ? onehot(exp) : 3'b000);
                end
                n_tests++;
                if ({s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o} !== {1'b1, pend_addr[exp], pend_wdata[exp], pend_wstrb[exp]}) begin
                    n_fail++; $display("FAIL rnd_payload%0d: s_avalid=%b addr=%h wdata=%h wstrb=%h expected 1 %h %h %h",
                                       t, s_avalid_o, s_addr_o, s_wdata_o, s_wstrb_o, pend_addr[exp], pend_wdata[exp], pend_wstrb[exp]);
                end
            end
            last_grant = exp;
            is_rd = (pend_wstrb[exp] == '0);
            pend_v[exp] = 1'b0;
            if (is_rd) begin
                lat = $urandom_range(1, TO + 2);
                answered = (lat <= TO);
                nrd = answered ? lat : TO + 1;
                rd = $urandom;
                for (int k = 1; k <= nrd; k++) begin
                    @(negedge clk);
                    drive_pend();
                    s_ready_i  = 1'($urandom);
                    s_rvalid_i = answered && (k == lat);
                    s_rdata_i  = (k == nrd) ? rd : $urandom;
                    #1;
                    n_tests++;
                    if (k < nrd) begin
                        if ({s_avalid_o, m_rvalid_o, m_rdata_o} !== '0) begin
                            n_fail++; $display("FAIL rnd_rdwait%0d: s_avalid=%b m_rvalid=%b m_rdata=%h expected 0", t, s_avalid_o, m_rvalid_o, m_rdata_o);
                        end
                    end else if ({m_rvalid_o, m_rdata_o} !== {onehot(exp), answered ? rd : 32'hFFFF_FFFF}) begin
                        n_fail++; $display("FAIL rnd_rdresp%0d: m_rvalid=%b m_rdata=%h expected %b %h",
                                           t, m_rvalid_o, m_rdata_o, onehot(exp), answered ? rd : 32'hFFFF_FFFF);
                    end
                end
                if (!answered) to_flag = 1'b1;
            end
        end
        @(negedge clk);
        clr_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clr_inputs();
        test_reset();
        test_single_write();
        test_read();
        test_contention();
        test_timeout();
        test_reset_in_rd();
        test_withdraw();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
